spi_flash_responder: RTL

//  Synthesizable SPI flash target (mode 0, single-bit I/O) that answers the on-chip SPI master.

---
 rtl/spi_flash_responder.sv | 271 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/spi_flash_responder.sv
// SPI mode-0 flash target that answers READ (0x03) and JEDEC ID (0x9F).
// SCLK/CSB/MOSI are oversampled on clk; read data is fetched from a one-cycle-latency byte store.
module spi_flash_responder #(
    parameter int unsigned ADDR_BITS   = 24,
    parameter logic [23:0] JEDEC_ID    = 24'hEF4018,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 spi_sclk,
    input  logic                 spi_csb,
    input  logic                 spi_mosi,
    output logic                 spi_miso,
    output logic                 spi_miso_oe,
    output logic                 rd_en,
    output logic [ADDR_BITS-1:0] rd_addr,
    input  logic [7:0]           rd_data,
    output logic                 busy,
    output logic [7:0]           last_cmd
);
    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_JEDEC = 8'h9F;
    localparam logic [ADDR_BITS-1:0] ADDR_ONE = {{(ADDR_BITS-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_ADDR   = 3'd2,
        ST_DATA   = 3'd3,
        ST_ID     = 3'd4,
        ST_IGNORE = 3'd5
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] csb_sync_q, csb_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   sclk_prev_q, sclk_prev_d;
    logic                   csb_prev_q, csb_prev_d;
    logic                   armed_q, armed_d;
    logic [4:0]             bit_cnt_q, bit_cnt_d;
    logic [22:0]            shift_q, shift_d;
    logic [ADDR_BITS-1:0]   addr_q, addr_d;
    logic [7:0]             tx_q, tx_d;
    logic [7:0]             prefetch_q, prefetch_d;
    logic                   fetch_pend_q, fetch_pend_d;
    logic                   byte_done_q, byte_done_d;
    logic [1:0]             id_idx_q, id_idx_d;
    logic                   miso_q, miso_d;
    logic                   oe_q, oe_d;
    logic                   rd_en_q, rd_en_d;
    logic [ADDR_BITS-1:0]   rd_addr_q, rd_addr_d;
    logic                   busy_q, busy_d;
    logic [7:0]             last_cmd_q, last_cmd_d;

    logic                   sclk_s, csb_s, mosi_s;
    logic                   sclk_rise_s, sclk_fall_s, csb_rise_s, csb_fall_s;
    logic [23:0]            shift_next_s;
    logic [7:0]             id_byte_s;
    logic [7:0]             load_byte_s;

    // The csb chain resets low so only a high actually sampled after reset can create a fall edge.
    assign sclk_s       = sclk_sync_q[SYNC_STAGES-1];
    assign csb_s        = csb_sync_q[SYNC_STAGES-1];
    assign mosi_s       = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise_s  = sclk_s & ~sclk_prev_q;
    assign sclk_fall_s  = ~sclk_s & sclk_prev_q;
    assign csb_rise_s   = csb_s & ~csb_prev_q;
    assign csb_fall_s   = ~csb_s & csb_prev_q;
    assign shift_next_s = {shift_q, mosi_s};

    // Synchronizer shift: raw pins enter at bit 0
    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
        csb_sync_d  = {csb_sync_q[SYNC_STAGES-2:0], spi_csb};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
    end

    // JEDEC ID byte selection, then 0xFF forever
    always_comb begin
        id_byte_s = 8'hFF;
        case (id_idx_q)
            2'd0:    id_byte_s = JEDEC_ID[23:16];
            2'd1:    id_byte_s = JEDEC_ID[15:8];
            2'd2:    id_byte_s = JEDEC_ID[7:0];
            default: id_byte_s = 8'hFF;
        endcase
    end

    // Protocol FSM: next state, shifters, fetch port and MISO drive
    always_comb begin
        state_d      = state_q;
        sclk_prev_d  = sclk_s;
        csb_prev_d   = csb_s;
        armed_d      = armed_q | csb_s;
        busy_d       = ~csb_s & armed_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        addr_d       = addr_q;
        tx_d         = tx_q;
        fetch_pend_d = rd_en_q;
        byte_done_d  = byte_done_q;
        id_idx_d     = id_idx_q;
        miso_d       = miso_q;
        oe_d         = oe_q;
        rd_en_d      = 1'b0;
        rd_addr_d    = rd_addr_q;
        last_cmd_d   = last_cmd_q;
        load_byte_s  = (state_q == ST_DATA) ? prefetch_q : id_byte_s;
        if (fetch_pend_q) begin
            prefetch_d = rd_data;
        end else begin
            prefetch_d = prefetch_q;
        end

        if (csb_rise_s) begin
            // CSB release beats any same-cycle SCLK edge and drops an in-flight fetch
            state_d      = ST_IDLE;
            oe_d         = 1'b0;
            miso_d       = 1'b0;
            bit_cnt_d    = 5'd0;
            byte_done_d  = 1'b0;
            id_idx_d     = 2'd0;
            fetch_pend_d = 1'b0;
            prefetch_d   = prefetch_q;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (csb_fall_s) begin
                        state_d   = ST_CMD;
                        bit_cnt_d = 5'd0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_CMD: begin
                    if (sclk_rise_s) begin
                        shift_d = shift_next_s[22:0];
                        if (bit_cnt_q == 5'd7) begin
                            bit_cnt_d   = 5'd0;
                            last_cmd_d  = shift_next_s[7:0];
                            byte_done_d = 1'b1;
                            id_idx_d    = 2'd0;
                            case (shift_next_s[7:0])
                                CMD_READ:  state_d = ST_ADDR;
                                CMD_JEDEC: state_d = ST_ID;
                                default:   state_d = ST_IGNORE;
                            endcase
                        end else begin
                            bit_cnt_d = bit_cnt_q + 5'd1;
                        end
                    end else begin
                        state_d = ST_CMD;
                    end
                end
                ST_ADDR: begin
                    if (sclk_rise_s) begin
                        shift_d = shift_next_s[22:0];
                        if (bit_cnt_q == 5'd23) begin
                            bit_cnt_d   = 5'd0;
                            addr_d      = shift_next_s[ADDR_BITS-1:0];
                            rd_addr_d   = shift_next_s[ADDR_BITS-1:0];
                            rd_en_d     = 1'b1;
                            byte_done_d = 1'b1;
                            state_d     = ST_DATA;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 5'd1;
                        end
                    end else begin
                        state_d = ST_ADDR;
                    end
                end
                ST_DATA, ST_ID: begin
                    if (sclk_fall_s) begin
                        if (byte_done_q) begin
                            // Byte start: present bit 7 and prefetch the following byte
                            miso_d      = load_byte_s[7];
                            tx_d        = {load_byte_s[6:0], 1'b0};
                            oe_d        = 1'b1;
                            byte_done_d = 1'b0;
                            if (state_q == ST_DATA) begin
                                addr_d    = addr_q + ADDR_ONE;
                                rd_addr_d = addr_q + ADDR_ONE;
                                rd_en_d   = 1'b1;
                            end else begin
                                id_idx_d = (id_idx_q == 2'd3) ? 2'd3 : id_idx_q + 2'd1;
                            end
                        end else begin
                            miso_d = tx_q[7];
                            tx_d   = {tx_q[6:0], 1'b0};
                        end
                    end else if (sclk_rise_s) begin
                        if (bit_cnt_q == 5'd7) begin
                            bit_cnt_d   = 5'd0;
                            byte_done_d = 1'b1;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 5'd1;
                        end
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_IGNORE: begin
                    oe_d = 1'b0;
                end
                default: begin
                    state_d = ST_IDLE;
                    oe_d    = 1'b0;
                    miso_d  = 1'b0;
                end
            endcase
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            sclk_sync_q  <= {SYNC_STAGES{1'b0}};
            csb_sync_q   <= {SYNC_STAGES{1'b0}};
            mosi_sync_q  <= {SYNC_STAGES{1'b0}};
            sclk_prev_q  <= 1'b0;
            csb_prev_q   <= 1'b0;
            armed_q      <= 1'b0;
            bit_cnt_q    <= 5'd0;
            shift_q      <= 23'd0;
            addr_q       <= {ADDR_BITS{1'b0}};
            tx_q         <= 8'h00;
            prefetch_q   <= 8'h00;
            fetch_pend_q <= 1'b0;
            byte_done_q  <= 1'b0;
            id_idx_q     <= 2'd0;
            miso_q       <= 1'b0;
            oe_q         <= 1'b0;
            rd_en_q      <= 1'b0;
            rd_addr_q    <= {ADDR_BITS{1'b0}};
            busy_q       <= 1'b0;
            last_cmd_q   <= 8'h00;
        end else begin
            state_q      <= state_d;
            sclk_sync_q  <= sclk_sync_d;
            csb_sync_q   <= csb_sync_d;
            mosi_sync_q  <= mosi_sync_d;
            sclk_prev_q  <= sclk_prev_d;
            csb_prev_q   <= csb_prev_d;
            armed_q      <= armed_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            addr_q       <= addr_d;
            tx_q         <= tx_d;
            prefetch_q   <= prefetch_d;
            fetch_pend_q <= fetch_pend_d;
            byte_done_q  <= byte_done_d;
            id_idx_q     <= id_idx_d;
            miso_q       <= miso_d;
            oe_q         <= oe_d;
            rd_en_q      <= rd_en_d;
            rd_addr_q    <= rd_addr_d;
            busy_q       <= busy_d;
            last_cmd_q   <= last_cmd_d;
        end
    end

    assign spi_miso    = miso_q;
    assign spi_miso_oe = oe_q;
    assign rd_en       = rd_en_q;
    assign rd_addr     = rd_addr_q;
    assign busy        = busy_q;
    assign last_cmd    = last_cmd_q;

endmodule
